// File: rtl/store_rmw_seq.sv
// -----------------------------------------------------------------------------
// store_rmw_seq
//
// Read-modify-write sequencer for sb/sh/sw stores in the multicycle CPU
// datapath. A sub-word store reads the addressed memory word and captures it
// as MR for the external combinational store mask. The mask's merged result
// is then registered and written back with a single write strobe. Word
// stores skip the read. Illegal size codes produce an err pulse and never
// touch memory.
//
// Parameters
//   MEM_LAT      cycles from mem_addr valid to mem_rd_data valid (1..7)
//
// Ports
//   clk          system clock, rising-edge active
//   reset        asynchronous, active-low reset
//   start        store request, honoured only while idle
//   addr         byte address of the store (latched on accepted start)
//   ct           store size: 0 = sw, 1 = sh, 2 = sb, 3 = illegal
//   busy         high in every state except idle
//   done         one-cycle pulse, store finished
//   err          one-cycle pulse, illegal size code
//   mem_addr     memory address; latched addr while busy, 0 when idle
//   mem_rd_data  memory read word
//   mem_wr       memory write strobe, one cycle per legal store
//   mem_wr_data  registered merged word
//   mr_out       captured memory word, drives store mask MR
//   ct_out       latched size code, drives store mask CT
//   merged_in    store mask OUT
// -----------------------------------------------------------------------------
module store_rmw_seq #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  ct,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr,
  output logic [31:0] mem_wr_data,
  output logic [31:0] mr_out,
  output logic [1:0]  ct_out,
  input  logic [31:0] merged_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_MERGE,
    S_WRITE,
    S_ERR
  } state_t;

  localparam logic [1:0] CT_SW      = 2'd0;
  localparam logic [1:0] CT_ILLEGAL = 2'd3;

  // Final count of the read wait; the read data is valid on the cycle after.
  localparam logic [2:0] READ_LAST = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] read_cnt;

  // mem_addr doubles as the latched store address: it only has to hold the
  // address while busy and read back 0 while idle, so no separate copy is kept.
  // ct_out likewise is the latched size code itself.
  //
  // NOTE: every state element here is updated with non-blocking assignments so
  // that all registers sample the values from before the clock edge; blocking
  // assignments would make later statements see already-updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      read_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_addr    <= '0;
      mem_wr      <= 1'b0;
      mem_wr_data <= '0;
      mr_out      <= '0;
      ct_out      <= '0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      done   <= 1'b0;
      err    <= 1'b0;
      mem_wr <= 1'b0;

      unique case (state)
        S_IDLE: begin
          // A start here may coincide with the done/err pulse of the previous
          // store, which gives back-to-back operation.
          if (start) begin
            mem_addr <= addr;
            ct_out   <= ct;
            busy     <= 1'b1;
            if (ct == CT_SW) begin
              // Full-word store: the mask passes B straight through, so the
              // memory word is not needed.
              state <= S_MERGE;
            end else if (ct == CT_ILLEGAL) begin
              state <= S_ERR;
            end else begin
              read_cnt <= '0;
              state    <= S_READ;
            end
          end
        end

        S_READ: begin
          // Wait out the memory latency; start is ignored in all busy states.
          if (read_cnt == READ_LAST) begin
            state <= S_CAPTURE;
          end else begin
            read_cnt <= read_cnt + 3'd1;
          end
        end

        S_CAPTURE: begin
          mr_out <= mem_rd_data;
          state  <= S_MERGE;
        end

        S_MERGE: begin
          // mr_out, ct_out and B have been stable for the whole cycle, so the
          // combinational mask output is settled here.
          mem_wr_data <= merged_in;
          mem_wr      <= 1'b1;
          state       <= S_WRITE;
        end

        S_WRITE: begin
          // mem_wr and mem_wr_data are high/stable for this one cycle.
          busy     <= 1'b0;
          mem_addr <= '0;
          done     <= 1'b1;
          state    <= S_IDLE;
        end

        S_ERR: begin
          busy     <= 1'b0;
          mem_addr <= '0;
          err      <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          busy     <= 1'b0;
          mem_addr <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_seq.sv
// -----------------------------------------------------------------------------
// tb_store_rmw_seq
//
// Bench for store_rmw_seq with MEM_LAT = 2. A small memory with a read
// pipeline of MEM_LAT stages and a behavioural store mask surround the DUT.
// Expected writes and done/err pulses, including the clock edge on which each
// must appear, are queued when a store is issued. A monitor compares them
// when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_store_rmw_seq;

  localparam int unsigned MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  ct = '0;
  logic        busy, done, err, mem_wr;
  logic [31:0] mem_addr, mem_rd_data, mem_wr_data, mr_out, merged_in;
  logic [1:0]  ct_out;
  logic [31:0] b_val = '0;

  always #5 clk = ~clk;

  store_rmw_seq #(.MEM_LAT(MEM_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .addr        (addr),
    .ct          (ct),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr      (mem_wr),
    .mem_wr_data (mem_wr_data),
    .mr_out      (mr_out),
    .ct_out      (ct_out),
    .merged_in   (merged_in)
  );

  // Store mask: places the low byte/half of B into the memory word.
  function automatic logic [31:0] store_mask(input logic [31:0] mr,
                                             input logic [31:0] b,
                                             input logic [1:0]  c);
    case (c)
      2'd0:    return b;
      2'd1:    return {mr[31:16], b[15:0]};
      2'd2:    return {mr[31:8], b[7:0]};
      default: return mr;
    endcase
  endfunction

  assign merged_in = store_mask(mr_out, b_val, ct_out);

  // Memory: 64 words indexed by addr[7:2], reads delayed by MEM_LAT edges.
  logic [31:0] mem [64];
  logic [31:0] rd_pipe [MEM_LAT];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_d = '0;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wr_data;
    else if (pre_en) mem[pre_idx] <= pre_d;
    rd_pipe[0] <= mem[mem_addr[7:2]];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = rd_pipe[MEM_LAT-1];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          at_edge;
  } wr_t;

  typedef struct {
    logic is_err;
    int   at_edge;
  } ev_t;

  wr_t wr_q[$];
  ev_t ev_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: every write strobe and every done/err pulse must match the
  // oldest outstanding expectation, on the expected edge.
  wr_t mon_w;
  ev_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_wr) begin
        check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          mon_w = wr_q.pop_front();
          check("wr_addr", mem_addr, mon_w.a);
          check("wr_data", mem_wr_data, mon_w.d);
          check("wr_cycle", 32'(edge_cnt), 32'(mon_w.at_edge));
        end
      end
      if (done || err) begin
        check("done_err_excl", 32'(done & err), 32'd0);
        check("ev_expected", 32'(ev_q.size() != 0), 32'd1);
        if (ev_q.size() != 0) begin
          mon_e = ev_q.pop_front();
          check("ev_is_err", 32'(err), 32'(mon_e.is_err));
          check("ev_cycle", 32'(edge_cnt), 32'(mon_e.at_edge));
        end
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_d   = d;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  // Drives start for one edge (DUT assumed idle) and queues the expected
  // outcome. Returns at the negedge of cycle 1.
  task automatic issue(input logic [31:0] a, input logic [1:0] c, input logic [31:0] b);
    int  e;
    wr_t w;
    ev_t v;
    e     = edge_cnt + 1;
    start = 1'b1;
    addr  = a;
    ct    = c;
    b_val = b;
    if (c == 2'd3) begin
      v.is_err  = 1'b1;
      v.at_edge = e + 1;
      ev_q.push_back(v);
    end else begin
      w.a       = a;
      w.d       = store_mask(mem[a[7:2]], b, c);
      w.at_edge = (c == 2'd0) ? e + 1 : e + int'(MEM_LAT) + 2;
      wr_q.push_back(w);
      v.is_err  = 1'b0;
      v.at_edge = w.at_edge + 1;
      ev_q.push_back(v);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
    check({tag, "_mr_out"}, mr_out, 32'd0);
    check({tag, "_ct_out"}, 32'(ct_out), 32'd0);
  endtask

  initial begin
    logic [31:0] hi;
    logic [31:0] d;
    logic [31:0] b;
    logic [31:0] exp_word;
    logic [5:0]  idx;
    logic [1:0]  c;

    // Reset state.
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // sb: busy cycles 1..5, mr_out captured by MERGE, memory merged after.
    preload(6'd16, 32'hFFFF_FFFF);
    issue(32'h40, 2'd2, 32'h8);
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("sb_busy_c%0d", i), 32'(busy), 32'(i <= 5));
      if (i == 1) check("sb_mem_addr", mem_addr, 32'h40);
      if (i == 4) check("sb_mr_out", mr_out, 32'hFFFF_FFFF);
      if (i == 4) check("sb_ct_out", 32'(ct_out), 32'd2);
      if (i == 6) check("sb_mem_addr_idle", mem_addr, 32'd0);
      if (i < 6) @(negedge clk);
    end
    check("sb_mem", mem[16], 32'hFFFF_FF08);

    // sh.
    preload(6'd16, 32'hFFFF_FFFF);
    issue(32'h40, 2'd1, 32'h8);
    wait_idle();
    check("sh_mem", mem[16], 32'hFFFF_0008);

    // sw: busy only cycles 1..2.
    preload(6'd16, 32'hFFFF_FFFF);
    issue(32'h40, 2'd0, 32'h8);
    check("sw_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    check("sw_busy_c2", 32'(busy), 32'd1);
    @(negedge clk);
    check("sw_busy_c3", 32'(busy), 32'd0);
    check("sw_mem", mem[16], 32'h0000_0008);

    // Illegal size code: err only, memory untouched.
    preload(6'd16, 32'hFFFF_FFFF);
    issue(32'h40, 2'd3, 32'h8);
    wait_idle();
    @(negedge clk);
    check("ill_mem", mem[16], 32'hFFFF_FFFF);

    // Start while busy is ignored.
    preload(6'd16, 32'hFFFF_FFFF);
    issue(32'h40, 2'd2, 32'h8);
    @(negedge clk);
    start = 1'b1;
    addr  = 32'h80;
    ct    = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check("ign_ct_out", 32'(ct_out), 32'd2);
    check("ign_mem_addr", mem_addr, 32'h40);
    wait_idle();
    check("ign_mem", mem[16], 32'hFFFF_FF08);

    // Reset in the MERGE cycle of an sb: everything clears at once.
    preload(6'd16, 32'hFFFF_FFFF);
    issue(32'h40, 2'd2, 32'h8);
    repeat (3) @(negedge clk);
    check("rst_pre_mr_out", mr_out, 32'hFFFF_FFFF);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    wr_q.delete();
    ev_q.delete();
    repeat (3) @(negedge clk);
    check("rst_mem", mem[16], 32'hFFFF_FFFF);
    // First edge after release accepts a store.
    reset = 1'b1;
    issue(32'h40, 2'd0, 32'h0000_00A5);
    wait_idle();
    check("rst_after_mem", mem[16], 32'h0000_00A5);

    // Back-to-back: second sw accepted in the done cycle of the first.
    issue(32'h44, 2'd0, 32'h1234_5678);
    repeat (2) @(negedge clk);
    check("b2b_done1", 32'(done), 32'd1);
    issue(32'h48, 2'd0, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_mem1", mem[17], 32'h1234_5678);
    check("b2b_mem2", mem[18], 32'hCAFE_F00D);

    // Random mix of sizes, data and addresses (upper and low bits unchecked
    // by the DUT, so they must flow to mem_addr unchanged).
    for (int n = 0; n < 12; n++) begin
      hi  = $urandom;
      d   = $urandom;
      b   = $urandom;
      idx = 6'($urandom_range(0, 63));
      c   = 2'($urandom_range(0, 3));
      preload(idx, d);
      issue({hi[31:8], idx, hi[1:0]}, c, b);
      wait_idle();
      @(negedge clk);
      exp_word = (c == 2'd3) ? d : store_mask(d, b, c);
      check($sformatf("rand%0d_mem", n), mem[idx], exp_word);
    end

    repeat (4) @(negedge clk);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("ev_q_drained", 32'(ev_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
